// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and access-legality helper for the data memory.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  function automatic logic funct3_bad(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects and sign/zero-extends the addressed byte/half/word of a load.
module dmem_load_align (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  import dmem_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[8*addr_lo +: 8];
  assign h = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'b0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'b0, h};
      F3_W:    data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - handshaked data memory with registered read, wait states, zero-init sweep and error responses.
// Defining DMEM_PERF_EN adds saturating load/store/error counters.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0,
  parameter int AW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          init_done
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]   perf_loads,
  output logic [31:0]   perf_stores,
  output logic [31:0]   perf_errs
`endif
);
  import dmem_pkg::*;

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [IW-1:0] LAST = IW'(DEPTH_WORDS - 1);
  localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam state_t FIRST_ST = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;

  state_t        state, state_n;
  logic [IW-1:0] cnt;
  logic [2:0]    wcnt;
  logic [31:0]   word_q;
  logic [1:0]    lo_q;
  logic [2:0]    f3_q;
  logic          err_q, ld_q;
  logic          accept, err, misal, oor, wr_en;
  logic [IW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   aligned;

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[IW+1:2];
  assign oor    = req_addr[AW-1:2] >= (AW-2)'(DEPTH_WORDS);
  assign err    = funct3_bad(req_we, req_funct3) | misal | oor;
  assign wr_en  = accept & req_we & ~err;

  always_comb begin
    misal = 1'b0;
    be    = 4'hF;
    wword = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        be    = 4'b0001 << req_addr[1:0];
        wword = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misal = req_addr[0];
        be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{req_wdata[15:0]}};
      end
      2'd2:    misal = |req_addr[1:0];
      default: misal = 1'b0;
    endcase
  end

  // One array per byte lane so partial stores never need a read-modify-write.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (state == ST_INIT) mem[cnt] <= '0;
      else if (wr_en && be[l]) mem[idx] <= wword[8*l +: 8];
      if (accept) rd_q <= mem[idx];
    end
    assign word_q[8*l +: 8] = rd_q;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_INIT: if (cnt == LAST) state_n = ST_IDLE;
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = FIRST_ST;
      end
      ST_WAIT: if (wcnt == 3'd0) state_n = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) state_n = req_valid ? FIRST_ST : ST_IDLE;
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      wcnt      <= '0;
      init_done <= 1'b0;
      lo_q      <= '0;
      f3_q      <= '0;
      err_q     <= 1'b0;
      ld_q      <= 1'b0;
`ifdef DMEM_PERF_EN
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) init_done <= 1'b1;
      end
      if (state == ST_WAIT) wcnt <= wcnt - 3'd1;
      if (accept) begin
        wcnt  <= WCNT_INIT;
        lo_q  <= req_addr[1:0];
        f3_q  <= req_funct3;
        err_q <= err;
        ld_q  <= ~req_we & ~err;
`ifdef DMEM_PERF_EN
        if (err) begin
          if (perf_errs != '1) perf_errs <= perf_errs + 1'b1;
        end else if (req_we) begin
          if (perf_stores != '1) perf_stores <= perf_stores + 1'b1;
        end else begin
          if (perf_loads != '1) perf_loads <= perf_loads + 1'b1;
        end
`endif
      end
    end
  end

  dmem_load_align u_align (
    .word    (word_q),
    .addr_lo (lo_q),
    .funct3  (f3_q),
    .data    (aligned)
  );

  // Outputs are gated by state so reset and non-response cycles read as zero.
  assign rsp_rdata = (state == ST_RESP && ld_q) ? aligned : '0;
  assign rsp_err   = (state == ST_RESP) && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench: byte-level memory model plus directed vectors for dmem_ctrl.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        req_ready, rsp_valid, rsp_err, init_done;

  logic        b_reset, b_req_valid, b_req_we, b_rsp_ready;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_init_done;

`ifdef DMEM_PERF_EN
  logic [31:0] pl, ps, pe, b_pl, b_ps, b_pe;
`endif

  dmem_ctrl #(.DEPTH_WORDS(DW), .WAIT_STATES(0), .AW(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done)
`ifdef DMEM_PERF_EN
    , .perf_loads(pl), .perf_stores(ps), .perf_errs(pe)
`endif
  );

  dmem_ctrl #(.DEPTH_WORDS(16), .WAIT_STATES(2), .AW(32)) dut_w (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .init_done(b_init_done)
`ifdef DMEM_PERF_EN
    , .perf_loads(b_pl), .perf_stores(b_ps), .perf_errs(b_pe)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  // Byte-addressed little-endian model of the memory contents.
  typedef struct {logic [31:0] rd; logic err;} rsp_t;
  logic [7:0] mm [DW*4];
  rsp_t       q[$];
  int         sweep_edges = 0;

  function automatic rsp_t model_access(input logic we, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
    rsp_t r;
    int n;
    logic legal;
    logic [31:0] v;
    n = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    r.err = !legal || (a % n) != 0 || (a / 4) >= DW;
    r.rd = '0;
    if (!r.err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mm[a+i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[a+i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        r.rd = v;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) sweep_edges = 0;
    else sweep_edges++;
  end

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      for (int i = 0; i < DW*4; i++) mm[i] = 8'h00;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_init_done", init_done, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
    end else begin
      check("init_done", init_done, sweep_edges >= DW);
      check("rsp_valid", rsp_valid, q.size() != 0);
      check("req_ready", req_ready, (sweep_edges >= DW) && (q.size() == 0 || rsp_ready));
      if (rsp_valid && q.size() != 0) begin
        check("rsp_rdata", rsp_rdata, q[0].rd);
        check("rsp_err", rsp_err, q[0].err);
        if (rsp_ready) void'(q.pop_front());
      end
      if (req_valid && req_ready) q.push_back(model_access(req_we, req_funct3, req_addr, req_wdata));
    end
  end

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    check("xact_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    check("xact_rsp", rsp_valid, 1);
    rd = rsp_rdata;
    e  = rsp_err;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vt [19] = '{
    '{1'b0, 3'd2, 32'h000, 32'h0,        32'h0000_0000, 1'b0},
    '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0000_0000, 1'b0},
    '{1'b0, 3'd0, 32'h103, 32'h0,        32'hFFFF_FFDE, 1'b0},
    '{1'b0, 3'd4, 32'h101, 32'h0,        32'h0000_00BE, 1'b0},
    '{1'b0, 3'd5, 32'h102, 32'h0,        32'h0000_DEAD, 1'b0},
    '{1'b0, 3'd1, 32'h100, 32'h0,        32'hFFFF_BEEF, 1'b0},
    '{1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0000_0000, 1'b0},
    '{1'b1, 3'd0, 32'h100, 32'h000000AA, 32'h0000_0000, 1'b0},
    '{1'b0, 3'd2, 32'h100, 32'h0,        32'h1234_BEAA, 1'b0},
    '{1'b0, 3'd2, 32'h101, 32'h0,        32'h0000_0000, 1'b1},
    '{1'b1, 3'd2, 32'h400, 32'h11111111, 32'h0000_0000, 1'b1},
    '{1'b0, 3'd2, 32'h000, 32'h0,        32'h0000_0000, 1'b0},
    '{1'b1, 3'd3, 32'h104, 32'h22222222, 32'h0000_0000, 1'b1},
    '{1'b0, 3'd2, 32'h104, 32'h0,        32'h0000_0000, 1'b0},
    '{1'b0, 3'd5, 32'h103, 32'h0,        32'h0000_0000, 1'b1},
    '{1'b0, 3'd6, 32'h100, 32'h0,        32'h0000_0000, 1'b1},
    '{1'b0, 3'd2, 32'h3FC, 32'h0,        32'h0000_0000, 1'b0},
    '{1'b1, 3'd2, 32'h3FC, 32'h89ABCDEF, 32'h0000_0000, 1'b0},
    '{1'b0, 3'd4, 32'h3FF, 32'h0,        32'h0000_0089, 1'b0}
  };

  logic        bw_we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0]  bw_f3 [4] = '{3'd2, 3'd2, 3'd2, 3'd1};
  logic [31:0] bw_a  [4] = '{32'h108, 32'h108, 32'h100, 32'h10A};

  initial begin
    logic [31:0] rd;
    logic        e;
    int          n, v;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    b_reset = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'd2;
    b_req_addr = 32'h4; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    n = 0;
    while (!init_done && n < 400) begin
      @(negedge clk);
      if (!init_done) n++;
    end
    check("init_cycles", n, DW);
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      xact(vt[i].we, vt[i].f3, vt[i].a, vt[i].wd, rd, e);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      check($sformatf("vec%0d_err", i), e, vt[i].err);
    end

    // Response held while the consumer stalls.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100; rsp_ready = 1'b1;
    @(negedge clk); check("stall_accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, 32'h1234_BEAA);
      check("stall_err", rsp_err, 0);
      check("stall_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); check("stall_release", rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk); check("stall_done", rsp_valid, 0);
    @(posedge clk); #1;

    // Back-to-back accesses, including a load of the word stored one cycle earlier.
    req_valid = 1'b1; rsp_ready = 1'b1; req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      req_we = bw_we[i]; req_funct3 = bw_f3[i]; req_addr = bw_a[i];
      @(negedge clk);
      check("b2b_ready", req_ready, 1);
      if (i > 0) check("b2b_valid", rsp_valid, 1);
      if (i == 2) check("raw_rdata", rsp_rdata, 32'hCAFE_F00D);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_valid", rsp_valid, 1);
    check("b2b_last_rdata", rsp_rdata, 32'hFFFF_CAFE);
    @(posedge clk); #1;

    // Second instance: two wait states, then reset while waiting.
    b_reset = 1'b0;
    n = 0;
    while (!b_init_done && n < 100) begin
      @(negedge clk);
      if (!b_init_done) n++;
    end
    check("w_init_cycles", n, 16);
    @(posedge clk); #1;
    b_req_valid = 1'b1;
    @(negedge clk); check("w_accept", b_req_ready, 1);
    @(posedge clk); #1 b_req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("w_lat%0d_valid", k), b_rsp_valid, k == 3);
      check($sformatf("w_lat%0d_ready", k), b_req_ready, k == 3);
      if (k == 3) begin
        check("w_rdata", b_rsp_rdata, 0);
        check("w_err", b_rsp_err, 0);
      end
      @(posedge clk); #1;
    end
    b_req_valid = 1'b1;
    @(negedge clk); check("w_accept2", b_req_ready, 1);
    @(posedge clk); #1 b_req_valid = 1'b0;
    @(negedge clk); check("w_wait_valid", b_rsp_valid, 0);
    check("w_wait_init", b_init_done, 1);
    b_reset = 1'b1;
    #1;
    check("w_rst_valid", b_rsp_valid, 0);
    check("w_rst_init", b_init_done, 0);
    check("w_rst_ready", b_req_ready, 0);
    @(posedge clk); #1 b_reset = 1'b0;
    n = 0; v = 0;
    while (!b_init_done && n < 100) begin
      @(negedge clk);
      if (b_rsp_valid) v++;
      if (!b_init_done) n++;
    end
    check("w_reinit_cycles", n, 16);
    check("w_no_stale_rsp", v, 0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
